// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S types and defaults for the receive and transmit paths
//
// Purpose: framing-state enum and default word width shared by the I2S blocks.
// Ports:   none (package).

package i2s_pkg;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam int DEFAULT_SAMPLE_BITS = 16;

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - synchronizes bclk/lrc/data into mclk and detects bclk rising edges
//
// Purpose: brings the three codec-driven I2S lines into the mclk domain through
//          SYNC_STAGES-deep flop chains and produces a one-cycle bclk rise strobe.
// Ports:
//   clk          in   mclk
//   rst          in   asynchronous active-high reset
//   bclk_i       in   raw bit clock
//   lrc_i        in   raw word select
//   dat_i        in   raw serial data
//   lrc_o        out  synchronized word select
//   dat_o        out  synchronized serial data
//   bclk_rise_o  out  one-cycle strobe on a synchronized bclk 0->1

module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk_i,
  input  logic lrc_i,
  input  logic dat_i,
  output logic lrc_o,
  output logic dat_o,
  output logic bclk_rise_o
);

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrc_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   bclk_prev_q;

  // All three lines use equal-depth chains so lrc/data stay aligned with the bclk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk_i};
      lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0], lrc_i};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], dat_i};
      bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign lrc_o       = lrc_sync_q[SYNC_STAGES-1];
  assign dat_o       = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise_o = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S capture path delivering stereo frames on a valid/ready interface
//
// Purpose: oversamples an external I2S link in the mclk domain, deserializes MSB-first
//          left/right words, locks framing on lrc 1->0 and hands complete stereo frames out.
// Ports:
//   mclk              in   sole clock (>= 4x bclk)
//   rst               in   asynchronous active-high reset
//   audio_I2S_bclk    in   codec bit clock
//   audio_I2S_reclrc  in   word select, 0 = left, 1 = right
//   audio_I2S_recdat  in   serial data, sampled on bclk rise
//   sample_left       out  left word of the held frame
//   sample_right      out  right word of the held frame
//   frame_valid       out  held frame valid
//   frame_ready       in   consumer accepts held frame
//   overrun           out  pulse: completed frame dropped because the stage was full
//   slot_err          out  pulse: a slot ended with the wrong bit count
//   link_up           out  framing locked and bclk active

module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS    = DEFAULT_SAMPLE_BITS,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   audio_I2S_bclk,
  input  logic                   audio_I2S_reclrc,
  input  logic                   audio_I2S_recdat,
  output logic [SAMPLE_BITS-1:0] sample_left,
  output logic [SAMPLE_BITS-1:0] sample_right,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   overrun,
  output logic                   slot_err,
  output logic                   link_up
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_BITS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SAMPLE_BITS-1:0] MSB_ONE = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  logic lrc_s, dat_s, bclk_rise;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (mclk),
    .rst         (rst),
    .bclk_i      (audio_I2S_bclk),
    .lrc_i       (audio_I2S_reclrc),
    .dat_i       (audio_I2S_recdat),
    .lrc_o       (lrc_s),
    .dat_o       (dat_s),
    .bclk_rise_o (bclk_rise)
  );

  i2s_rx_state_t          state_q, state_d;
  logic                   lrc_prev_q, lrc_prev_d;
  logic [SAMPLE_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TW-1:0]          to_q, to_d;
  logic [SAMPLE_BITS-1:0] lword_q, lword_d;
  logic [SAMPLE_BITS-1:0] rword_q, rword_d;
  logic                   done_q, done_d;
  logic                   slot_err_q, slot_err_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic [SAMPLE_BITS-1:0] right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic [SAMPLE_BITS-1:0] bit_vec;
  logic [SAMPLE_BITS-1:0] slot_word;

  always_comb begin
    state_d    = state_q;
    lrc_prev_d = lrc_prev_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    lword_d    = lword_q;
    rword_d    = rword_q;
    done_d     = 1'b0;
    slot_err_d = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;

    // Bits are placed left-aligned at their final position as they arrive, so a short
    // slot is zero-padded for free and bits past SAMPLE_BITS shift out to nothing.
    bit_vec   = dat_s ? (MSB_ONE >> cnt_q) : '0;
    slot_word = sr_q | bit_vec;

    if (bclk_rise) begin
      to_d       = '0;
      lrc_prev_d = lrc_s;
      if (lrc_s != lrc_prev_q) begin
        // One-bit I2S delay: this bit is the LSB of the slot that lrc_prev owned.
        sr_d  = '0;
        cnt_d = '0;
        unique case (state_q)
          SEEK: if (!lrc_s) state_d = LEFT;
          LEFT: if (lrc_s) begin
            lword_d    = slot_word;
            slot_err_d = (cnt_q != CNT_LAST);
            state_d    = RIGHT;
          end
          RIGHT: if (!lrc_s) begin
            rword_d    = slot_word;
            slot_err_d = (cnt_q != CNT_LAST);
            done_d     = 1'b1;
            state_d    = LEFT;
          end
          default: state_d = SEEK;
        endcase
      end else begin
        sr_d = slot_word;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
    end else if (to_q == TO_LAST) begin
      // Link lost: hold here until bclk returns; the output stage is left untouched.
      state_d = SEEK;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      to_d = to_q + 1'b1;
    end

    if (done_q) begin
      if (!valid_q || frame_ready) begin
        left_d  = lword_q;
        right_d = rword_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q    <= SEEK;
      lrc_prev_q <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      lword_q    <= '0;
      rword_q    <= '0;
      done_q     <= 1'b0;
      slot_err_q <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrc_prev_q <= lrc_prev_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      lword_q    <= lword_d;
      rword_q    <= rword_d;
      done_q     <= done_d;
      slot_err_q <= slot_err_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign frame_valid  = valid_q;
  assign overrun      = overrun_q;
  assign slot_err     = slot_err_q;
  assign link_up      = (state_q != SEEK);

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - directed self-checking bench for i2s_receiver

module tb_i2s_receiver;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        bclk = 1'b0;
  logic        lrc = 1'b0;
  logic        dat = 1'b0;
  logic        frame_ready = 1'b1;
  logic [15:0] sample_left, sample_right;
  logic        frame_valid, overrun, slot_err, link_up;

  i2s_receiver #(.SAMPLE_BITS(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut (
    .mclk             (mclk),
    .rst              (rst),
    .audio_I2S_bclk   (bclk),
    .audio_I2S_reclrc (lrc),
    .audio_I2S_recdat (dat),
    .sample_left      (sample_left),
    .sample_right     (sample_right),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .overrun          (overrun),
    .slot_err         (slot_err),
    .link_up          (link_up)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;
  int cap_n = 0;
  int ov_n = 0;
  int se_n = 0;
  logic [15:0] last_l = '0;
  logic [15:0] last_r = '0;

  // Records every accepted frame and every status pulse.
  always @(negedge mclk) begin
    if (frame_valid && frame_ready) begin
      cap_n  <= cap_n + 1;
      last_l <= sample_left;
      last_r <= sample_right;
    end
    if (overrun) ov_n <= ov_n + 1;
    if (slot_err) se_n <= se_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // One bclk period = 16 mclk; lrc/data change while bclk is low.
  task automatic send_bit(input logic l, input logic d);
    bclk = 1'b0;
    lrc  = l;
    dat  = d;
    tick(8);
    bclk = 1'b1;
    tick(8);
  endtask

  // n bits MSB first; the LSB goes out after lrc has already flipped.
  task automatic send_slot(input logic ch, input logic [31:0] w, input int n);
    logic [31:0] wv;
    wv = w;
    for (int i = n - 1; i >= 1; i--) send_bit(ch, wv[i]);
    send_bit(~ch, wv[0]);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, {16'h0, l}, 16);
    send_slot(1'b1, {16'h0, r}, 16);
  endtask

  task automatic send_sync();
    send_slot(1'b1, 32'h0, 16);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    check("rst_valid", frame_valid, 0);
    check("rst_link", link_up, 0);
    check("rst_words", {sample_left, sample_right}, 0);
    check("rst_pulses", {overrun, slot_err}, 0);
    rst = 1'b0;
    tick(2);

    // 1: basic frames
    send_sync();
    check("t1_link", link_up, 1);
    send_frame(16'hA5C3, 16'h7F01);
    check("t1_cap1_n", cap_n, 1);
    check("t1_cap1_l", last_l, 16'hA5C3);
    check("t1_cap1_r", last_r, 16'h7F01);
    send_frame(16'h0000, 16'h0000);
    send_frame(16'h8000, 16'h0001);
    check("t1_cap3_n", cap_n, 3);
    check("t1_cap3_l", last_l, 16'h8000);
    check("t1_cap3_r", last_r, 16'h0001);
    check("t1_ov", ov_n, 0);
    check("t1_se", se_n, 0);

    // 2: backpressure and overrun
    frame_ready = 1'b0;
    send_frame(16'h1234, 16'h5678);
    check("t2_valid", frame_valid, 1);
    check("t2_words", {sample_left, sample_right}, 32'h12345678);
    send_frame(16'hDEAD, 16'hBEEF);
    check("t2_hold_words", {sample_left, sample_right}, 32'h12345678);
    check("t2_hold_valid", frame_valid, 1);
    check("t2_ov", ov_n, 1);
    check("t2_nocap", cap_n, 3);
    frame_ready = 1'b1;
    tick(1);
    check("t2_hs_valid", frame_valid, 0);
    check("t2_hs_cap", cap_n, 4);
    check("t2_hs_words", {last_l, last_r}, 32'h12345678);
    check("t2_keep_words", {sample_left, sample_right}, 32'h12345678);

    // 3: reset released mid right slot
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1, i[0]);
    check("t3_unlocked", link_up, 0);
    send_bit(1'b0, 1'b1);
    check("t3_locked", link_up, 1);
    check("t3_nocap", cap_n, 4);
    send_frame(16'h1357, 16'h2468);
    check("t3_cap", cap_n, 5);
    check("t3_words", {last_l, last_r}, 32'h13572468);

    // 4: short and long left slots
    send_slot(1'b0, 32'h0000_0ABC, 12);
    send_slot(1'b1, 32'h0000_1111, 16);
    check("t4_short_cap", cap_n, 6);
    check("t4_short_words", {last_l, last_r}, 32'hABC01111);
    check("t4_short_se", se_n, 1);
    send_slot(1'b0, 32'h000A_BCDE, 20);
    send_slot(1'b1, 32'h0000_0F0F, 16);
    check("t4_long_cap", cap_n, 7);
    check("t4_long_words", {last_l, last_r}, 32'hABCD0F0F);
    check("t4_long_se", se_n, 2);

    // 5: bclk stall mid left slot with a held frame
    frame_ready = 1'b0;
    send_frame(16'h4444, 16'h5555);
    check("t5_held", frame_valid, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    tick(1000);
    check("t5_link_before", link_up, 1);
    tick(100);
    check("t5_link_lost", link_up, 0);
    check("t5_still_valid", frame_valid, 1);
    check("t5_still_words", {sample_left, sample_right}, 32'h44445555);
    frame_ready = 1'b1;
    tick(1);
    check("t5_hs_valid", frame_valid, 0);
    check("t5_hs_cap", cap_n, 8);
    send_sync();
    check("t5_relock", link_up, 1);
    send_frame(16'h6666, 16'h7777);
    check("t5_cap", cap_n, 9);
    check("t5_words", {last_l, last_r}, 32'h66667777);

    // 6: asynchronous reset while a frame is held
    frame_ready = 1'b0;
    send_frame(16'h9999, 16'hAAAA);
    check("t6_held", frame_valid, 1);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", frame_valid, 0);
    check("t6_async_words", {sample_left, sample_right}, 0);
    check("t6_async_status", {link_up, overrun, slot_err}, 0);
    tick(2);
    rst = 1'b0;
    frame_ready = 1'b1;
    tick(20);
    check("t6_nostale", cap_n, 9);
    send_sync();
    send_frame(16'hBBBB, 16'hCCCC);
    check("t6_cap", cap_n, 10);
    check("t6_words", {last_l, last_r}, 32'hBBBBCCCC);
    check("t6_ov_total", ov_n, 1);
    check("t6_se_total", se_n, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
